// File: rtl/exe_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the EXE stage.
// Stalls the pipeline while iterating and produces LO (quotient) / HI (remainder).
module exe_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             EXE_DivStart,
    input  logic             EXE_DivSigned,
    input  logic [WIDTH-1:0] EXE_BusA,
    input  logic [WIDTH-1:0] EXE_BusB,
    input  logic             MEM_Flush,
    output logic             EXE_DivBusy,
    output logic             EXE_DivDone,
    output logic [WIDTH-1:0] EXE_DivQuot,
    output logic [WIDTH-1:0] EXE_DivRem
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_r, quo_r, dvs_r, raw_a;
    logic             neg_q, neg_r, div_zero;

    logic             accept;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   rem_sh;
    logic             borrow;
    logic [WIDTH-1:0] diff, rem_nx, quo_nx, quot_fin, rem_fin;

    assign accept = (state == IDLE) && EXE_DivStart && !MEM_Flush;

    // Magnitudes: 0x80000000 negates to itself, which is the correct unsigned magnitude.
    assign abs_a = (EXE_DivSigned && EXE_BusA[WIDTH-1]) ? -EXE_BusA : EXE_BusA;
    assign abs_b = (EXE_DivSigned && EXE_BusB[WIDTH-1]) ? -EXE_BusB : EXE_BusB;

    // One restoring step: shift {rem,quo} left, trial-subtract the divisor.
    always_comb begin
        rem_sh = {rem_r, quo_r[WIDTH-1]};
        borrow = rem_sh < {1'b0, dvs_r};
        diff   = rem_sh[WIDTH-1:0] - dvs_r;
        rem_nx = borrow ? rem_sh[WIDTH-1:0] : diff;
        quo_nx = {quo_r[WIDTH-2:0], ~borrow};
    end

    // Divide-by-zero bypasses sign correction: all-ones quotient, raw dividend as remainder.
    always_comb begin
        if (div_zero) begin
            quot_fin = '1;
            rem_fin  = raw_a;
        end else begin
            quot_fin = neg_q ? -quo_nx : quo_nx;
            rem_fin  = neg_r ? -rem_nx : rem_nx;
        end
    end

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_nx    = state;
        EXE_DivBusy = 1'b0;
        EXE_DivDone = 1'b0;
        case (state)
            IDLE: begin
                EXE_DivBusy = accept;
                if (accept) state_nx = CALC;
            end
            CALC: begin
                EXE_DivBusy = 1'b1;
                if (MEM_Flush)              state_nx = IDLE;
                else if (cnt == LAST_STEP)  state_nx = DONE;
            end
            DONE: begin
                EXE_DivDone = !MEM_Flush;
                state_nx    = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            rem_r       <= '0;
            quo_r       <= '0;
            dvs_r       <= '0;
            raw_a       <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            div_zero    <= 1'b0;
            EXE_DivQuot <= '0;
            EXE_DivRem  <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                cnt      <= '0;
                rem_r    <= '0;
                quo_r    <= abs_a;
                dvs_r    <= abs_b;
                raw_a    <= EXE_BusA;
                neg_q    <= EXE_DivSigned && (EXE_BusA[WIDTH-1] ^ EXE_BusB[WIDTH-1]);
                neg_r    <= EXE_DivSigned && EXE_BusA[WIDTH-1];
                div_zero <= (EXE_BusB == '0);
            end else if (state == CALC && !MEM_Flush) begin
                cnt   <= cnt + 1'b1;
                rem_r <= rem_nx;
                quo_r <= quo_nx;
                if (cnt == LAST_STEP) begin
                    EXE_DivQuot <= quot_fin;
                    EXE_DivRem  <= rem_fin;
                end
            end
        end
    end

endmodule

// File: tb/tb_exe_div_unit.sv
// Self-checking bench for exe_div_unit: directed corner cases plus random DIV/DIVU,
// scoreboard queue filled at issue time and drained by a Done-driven monitor.
module tb_exe_div_unit;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         EXE_DivStart = 1'b0;
    logic         EXE_DivSigned = 1'b0;
    logic [W-1:0] EXE_BusA = '0;
    logic [W-1:0] EXE_BusB = '0;
    logic         MEM_Flush = 1'b0;
    logic         EXE_DivBusy;
    logic         EXE_DivDone;
    logic [W-1:0] EXE_DivQuot;
    logic [W-1:0] EXE_DivRem;

    exe_div_unit #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .EXE_DivStart (EXE_DivStart),
        .EXE_DivSigned(EXE_DivSigned),
        .EXE_BusA     (EXE_BusA),
        .EXE_BusB     (EXE_BusB),
        .MEM_Flush    (MEM_Flush),
        .EXE_DivBusy  (EXE_DivBusy),
        .EXE_DivDone  (EXE_DivDone),
        .EXE_DivQuot  (EXE_DivQuot),
        .EXE_DivRem   (EXE_DivRem)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           issue;
    } exp_t;

    exp_t         sb_q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer division, truncating toward zero for signed operands.
    function automatic void model(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa, sb, lq, lr;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[W-1:0];
            r  = lr[W-1:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Monitor: every Done pulse must match the oldest outstanding operation.
    always @(negedge clk) begin
        if (!rst && EXE_DivDone) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: Done pulse with no operation pending (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("quot", EXE_DivQuot, e.q);
                check("rem", EXE_DivRem, e.r);
                check("done_latency", cyc - e.issue, LAT);
            end
        end
    end

    // Called at posedge+1; holds Start until Busy drops, scrambling operands meanwhile.
    task automatic do_op(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q, r;
        int  busy_cnt;
        bit  dropped;
        EXE_DivStart  = 1'b1;
        EXE_DivSigned = s;
        EXE_BusA      = a;
        EXE_BusB      = b;
        model(s, a, b, q, r);
        sb_q.push_back('{q: q, r: r, issue: cyc});
        last_q   = q;
        last_r   = r;
        busy_cnt = 0;
        dropped  = 0;
        for (int i = 0; i < LAT + 8; i++) begin
            @(negedge clk);
            if (!EXE_DivBusy) begin
                dropped = 1;
                break;
            end
            busy_cnt++;
            @(posedge clk);
            #1;
            EXE_BusA      = $urandom;
            EXE_BusB      = $urandom;
            EXE_DivSigned = $urandom_range(0, 1);
        end
        check("busy_dropped", dropped, 1);
        check("busy_cycles", busy_cnt, LAT);
        @(posedge clk);
        #1;
        EXE_DivStart = 1'b0;
    endtask

    initial begin
        int t0;
        @(negedge clk);
        check("rst_quot", EXE_DivQuot, 0);
        check("rst_rem", EXE_DivRem, 0);
        check("rst_busy", EXE_DivBusy, 0);
        check("rst_done", EXE_DivDone, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed corner cases, back to back.
        do_op(0, 32'd100, 32'd7);
        do_op(1, 32'hFFFF_FFF9, 32'd2);
        do_op(1, 32'd7, 32'hFFFF_FFFE);
        do_op(1, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(0, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(0, 32'd5, 32'd0);
        do_op(1, 32'hFFFF_FFFB, 32'd0);

        // Flush in cycle 10 of an operation: no Done, prior results retained.
        t0 = cyc;
        EXE_DivStart  = 1'b1;
        EXE_DivSigned = 1'b0;
        EXE_BusA      = 32'd100;
        EXE_BusB      = 32'd7;
        while (cyc < t0 + 10) begin
            @(posedge clk);
            #1;
        end
        MEM_Flush = 1'b1;
        @(posedge clk);
        #1;
        MEM_Flush    = 1'b0;
        EXE_DivStart = 1'b0;
        @(negedge clk);
        check("flush_busy", EXE_DivBusy, 0);
        check("flush_quot_held", EXE_DivQuot, last_q);
        check("flush_rem_held", EXE_DivRem, last_r);
        @(posedge clk);
        #1;
        check("flush_restart_cycle", cyc - t0, 12);
        do_op(0, 32'd9, 32'd4);

        // Asynchronous reset in the middle of cycle 20 of an operation.
        t0 = cyc;
        EXE_DivStart  = 1'b1;
        EXE_DivSigned = 1'b0;
        EXE_BusA      = 32'd100;
        EXE_BusB      = 32'd7;
        while (cyc < t0 + 20) begin
            @(posedge clk);
            #1;
        end
        #3;
        rst          = 1'b1;
        EXE_DivStart = 1'b0;
        #1;
        check("arst_quot", EXE_DivQuot, 0);
        check("arst_rem", EXE_DivRem, 0);
        check("arst_busy", EXE_DivBusy, 0);
        check("arst_done", EXE_DivDone, 0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        last_q = '0;
        last_r = '0;
        @(posedge clk);
        #1;
        do_op(0, 32'd8, 32'd3);

        // Randomized operations with biased corner operands.
        for (int i = 0; i < 24; i++) begin
            bit           s;
            logic [W-1:0] a, b;
            s = $urandom_range(0, 1);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: b = W'($urandom_range(1, 15));
                2: begin a = 32'h8000_0000; b = '1; end
                3: b = '1;
                4: a = W'($urandom_range(0, 255));
                5: b = 32'd1;
                default: ;
            endcase
            do_op(s, a, b);
        end

        repeat (4) @(posedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
